// File: rtl/bft_pkg.sv
// bft_pkg: BFT packet field layout, kind constants, egress FSM states and pack/unpack helpers shared with the leaf side
package bft_pkg;
  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 4;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int NUM_BRAM_ADDR_BITS    = 8;
  localparam int FREESPACE_UPDATE_SIZE = 64;
  localparam int POP_BITS              = $clog2(FREESPACE_UPDATE_SIZE);
  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 44;
  localparam int PORT_LSB  = 40;
  localparam int SEQ_LSB   = 33;
  localparam int KIND_BIT  = 32;
  localparam logic KIND_DATA = 1'b0;
  localparam logic KIND_CRED = 1'b1;
  localparam logic [NUM_BRAM_ADDR_BITS:0] CREDIT_MAX = (NUM_BRAM_ADDR_BITS+1)'(2**NUM_BRAM_ADDR_BITS);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRED} state_t;
  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] seq;
    logic                     kind;
    logic [PAYLOAD_BITS-1:0]  payload;
  } bft_pkt_t;
  function automatic logic [PACKET_BITS-1:0] bft_pack(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] seq,
    input logic                     kind,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    return {1'b1, leaf, port, seq, kind, payload};
  endfunction
  function automatic bft_pkt_t bft_unpack(input logic [PACKET_BITS-1:0] p);
    bft_pkt_t r;
    r.valid   = p[VALID_BIT];
    r.leaf    = p[LEAF_LSB +: NUM_LEAF_BITS];
    r.port    = p[PORT_LSB +: NUM_PORT_BITS];
    r.seq     = p[SEQ_LSB +: NUM_ADDR_BITS];
    r.kind    = p[KIND_BIT];
    r.payload = p[PAYLOAD_BITS-1:0];
    return r;
  endfunction
endpackage

// File: rtl/bft_ep_rx_fifo.sv
// bft_ep_rx_fifo: synchronous first-word-fall-through FIFO with full/empty flags and a registered count
module bft_ep_rx_fifo
  import bft_pkg::*;
#(
  parameter int AW = NUM_BRAM_ADDR_BITS,
  parameter int DW = PAYLOAD_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;
  assign full    = count_q[AW];
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign dout    = mem[rptr_q];
  // a push into a full FIFO is taken only when the same cycle frees a slot
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  always_comb begin
    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop_ok);
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= din;
  end
endmodule

// File: rtl/bft_host_endpoint.sv
// bft_host_endpoint: host-side BFT endpoint; credit-limited egress packer and buffered ingress with credit return
// Defining SEQ_CHECK_EN adds rx sequence tracking and a sticky err_seq output.
module bft_host_endpoint
  import bft_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PACKET_BITS-1:0]      din_bft,
  output logic [PACKET_BITS-1:0]      dout_bft,
  input  logic [NUM_LEAF_BITS-1:0]    cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]    cfg_dst_port,
  input  logic [PAYLOAD_BITS-1:0]     din_host,
  input  logic                        vld_host2ep,
  output logic                        ack_ep2host,
  output logic [PAYLOAD_BITS-1:0]     dout_host,
  output logic                        vld_ep2host,
  input  logic                        ack_host2ep,
  output logic [NUM_BRAM_ADDR_BITS:0] credits,
`ifdef SEQ_CHECK_EN
  output logic                        err_seq,
`endif
  output logic                        err_ovf
);
  state_t                        state_q, state_d;
  logic [PACKET_BITS-1:0]        dout_q, dout_d;
  logic [NUM_BRAM_ADDR_BITS:0]   credits_q, credits_d, fifo_count;
  logic [NUM_BRAM_ADDR_BITS+1:0] cred_sum;
  logic [NUM_ADDR_BITS-1:0]      tx_seq_q, tx_seq_d;
  logic [POP_BITS-1:0]           pop_cnt_q, pop_cnt_d;
  logic [1:0]                    queued_q, queued_d;
  logic                          pending_q, pending_d, err_ovf_q, err_ovf_d;
  logic                          rx_data, rx_cred, accept, pop, wrap, cred_fire, full, empty, unused_ok;
  bft_pkt_t                      rx;
  assign rx          = bft_unpack(din_bft);
  assign rx_data     = rx.valid && rx.kind == KIND_DATA;
  assign rx_cred     = rx.valid && rx.kind == KIND_CRED;
  assign ack_ep2host = !reset && state_q == S_IDLE && !pending_q && credits_q != '0;
  assign accept      = vld_host2ep && ack_ep2host;
  assign vld_ep2host = !empty;
  assign pop         = vld_ep2host && ack_host2ep;
  assign wrap        = pop && pop_cnt_q == POP_BITS'(FREESPACE_UPDATE_SIZE-1);
  assign cred_fire   = state_q == S_IDLE && pending_q;
  assign dout_bft    = dout_q;
  assign credits     = credits_q;
  assign err_ovf     = err_ovf_q;
  bft_ep_rx_fifo u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_data),
    .din   (rx.payload),
    .pop   (pop),
    .dout  (dout_host),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  always_comb begin
    state_d = S_IDLE;
    dout_d  = '0;
    if (cred_fire) begin
      state_d = S_CRED;
      dout_d  = bft_pack(cfg_dst_leaf, cfg_dst_port, tx_seq_q, KIND_CRED, PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE));
    end else if (accept) begin
      state_d = S_DATA;
      dout_d  = bft_pack(cfg_dst_leaf, cfg_dst_port, tx_seq_q, KIND_DATA, din_host);
    end
    // returned credit and a sent packet in the same cycle net out before saturation
    cred_sum  = {1'b0, credits_q} + (rx_cred ? {1'b0, rx.payload[NUM_BRAM_ADDR_BITS:0]} : '0)
              - (NUM_BRAM_ADDR_BITS+2)'(accept);
    credits_d = cred_sum > {1'b0, CREDIT_MAX} ? CREDIT_MAX : cred_sum[NUM_BRAM_ADDR_BITS:0];
    tx_seq_d  = tx_seq_q + NUM_ADDR_BITS'(accept);
    pop_cnt_d = pop_cnt_q + POP_BITS'(pop);
    pending_d = cred_fire && queued_q == '0 ? 1'b0 : pending_q;
    queued_d  = cred_fire && queued_q != '0 ? queued_q - 2'd1 : queued_q;
    if (wrap) begin
      if (!pending_d) pending_d = 1'b1;
      else queued_d = queued_d == 2'd3 ? 2'd3 : queued_d + 2'd1;
    end
    err_ovf_d = err_ovf_q | (rx_data && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dout_q    <= '0;
      credits_q <= CREDIT_MAX;
      tx_seq_q  <= '0;
      pop_cnt_q <= '0;
      pending_q <= 1'b0;
      queued_q  <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      credits_q <= credits_d;
      tx_seq_q  <= tx_seq_d;
      pop_cnt_q <= pop_cnt_d;
      pending_q <= pending_d;
      queued_q  <= queued_d;
      err_ovf_q <= err_ovf_d;
    end
  end
`ifdef SEQ_CHECK_EN
  logic [NUM_ADDR_BITS-1:0] exp_seq_q, exp_seq_d;
  logic                     err_seq_q, err_seq_d;
  always_comb begin
    exp_seq_d = rx_data ? rx.seq + NUM_ADDR_BITS'(1) : exp_seq_q;
    err_seq_d = err_seq_q | (rx_data && rx.seq != exp_seq_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_seq_q <= '0;
      err_seq_q <= 1'b0;
    end else begin
      exp_seq_q <= exp_seq_d;
      err_seq_q <= err_seq_d;
    end
  end
  assign err_seq   = err_seq_q;
  assign unused_ok = ^{rx.leaf, rx.port, fifo_count};
`else
  assign unused_ok = ^{rx.leaf, rx.port, rx.seq, fifo_count};
`endif
endmodule

// File: tb/tb_bft_host_endpoint.sv
// tb_bft_host_endpoint: directed vector bench for the host endpoint egress, credit and ingress paths
module tb_bft_host_endpoint;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [48:0] din_bft = '0;
  logic [48:0] dout_bft;
  logic [3:0]  cfg_dst_leaf = 4'd7;
  logic [3:0]  cfg_dst_port = 4'd1;
  logic [31:0] din_host = '0;
  logic        vld_host2ep = 1'b0;
  logic        ack_ep2host;
  logic [31:0] dout_host;
  logic        vld_ep2host;
  logic        ack_host2ep = 1'b0;
  logic [8:0]  credits;
  logic        err_ovf;
`ifdef SEQ_CHECK_EN
  logic        err_seq;
`endif
  int checks = 0;
  int errors = 0;

  bft_host_endpoint dut (
    .clk          (clk),
    .reset        (reset),
    .din_bft      (din_bft),
    .dout_bft     (dout_bft),
    .cfg_dst_leaf (cfg_dst_leaf),
    .cfg_dst_port (cfg_dst_port),
    .din_host     (din_host),
    .vld_host2ep  (vld_host2ep),
    .ack_ep2host  (ack_ep2host),
    .dout_host    (dout_host),
    .vld_ep2host  (vld_ep2host),
    .ack_host2ep  (ack_host2ep),
    .credits      (credits),
`ifdef SEQ_CHECK_EN
    .err_seq      (err_seq),
`endif
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] din;
    logic [3:0]  leaf;
    logic [3:0]  port;
    logic [6:0]  seq;
    logic [8:0]  cred;
  } egr_vec_t;

  typedef struct {
    logic [31:0] pay;
    logic [8:0]  cred;
  } crd_vec_t;

  egr_vec_t ev [4];
  crd_vec_t cv [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [48:0] mk(input logic kind, input logic [6:0] seq, input logic [31:0] pay);
    return {1'b1, 4'd0, 4'd0, seq, kind, pay};
  endfunction

  task automatic inj(input logic [48:0] p);
    din_bft = p;
    step();
    din_bft = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // offers one host word; inj is driven onto din_bft in the accepting cycle
  task automatic send_word(input logic [31:0] w, input logic [48:0] p, output bit ok);
    ok = 1'b0;
    din_host = w;
    vld_host2ep = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_ep2host) begin
        ok = 1'b1;
        din_bft = p;
        break;
      end
    end
    step();
    vld_host2ep = 1'b0;
    din_bft = '0;
  endtask

  initial begin
    bit ok;
    int nok, bad, cnt, ncred, order_bad;
    logic [48:0] cred_pkt;
    logic [31:0] exp_w;
    ev[0] = '{32'hA, 4'd7, 4'd1, 7'd0, 9'd255};
    ev[1] = '{32'hB, 4'd7, 4'd1, 7'd1, 9'd254};
    ev[2] = '{32'hC, 4'd7, 4'd1, 7'd2, 9'd253};
    ev[3] = '{32'hD, 4'd3, 4'd2, 7'd3, 9'd252};
    cv[0] = '{32'd100, 9'd112};
    cv[1] = '{32'd100, 9'd212};
    cv[2] = '{32'd100, 9'd256};
    cv[3] = '{32'd0,   9'd256};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout_bft", 64'(dout_bft), 64'(0));
    check("rst_ack", 64'(ack_ep2host), 64'(0));
    check("rst_vld_ep2host", 64'(vld_ep2host), 64'(0));
    check("rst_credits", 64'(credits), 64'(256));
    check("rst_err_ovf", 64'(err_ovf), 64'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    check("ack_after_reset", 64'(ack_ep2host), 64'(1));
    step();

    for (int i = 0; i < 4; i++) begin
      cfg_dst_leaf = ev[i].leaf;
      cfg_dst_port = ev[i].port;
      send_word(ev[i].din, '0, ok);
      check("egr_accept", 64'(ok), 64'(1));
      @(negedge clk);
      check("egr_pkt", 64'(dout_bft), 64'({1'b1, ev[i].leaf, ev[i].port, ev[i].seq, 1'b0, ev[i].din}));
      check("egr_credits", 64'(credits), 64'(ev[i].cred));
      step();
      @(negedge clk);
      check("egr_pulse_end", 64'(dout_bft), 64'(0));
      step();
    end
    cfg_dst_leaf = 4'd7;
    cfg_dst_port = 4'd1;

    do_reset();
    nok = 0;
    for (int i = 0; i < 256; i++) begin
      send_word(32'(i), '0, ok);
      if (!ok) nok++;
    end
    check("exhaust_256_accepted", 64'(nok), 64'(0));
    @(negedge clk);
    check("exhaust_credits", 64'(credits), 64'(0));
    step();
    vld_host2ep = 1'b1;
    step();
    step();
    @(negedge clk);
    check("exhaust_ack_low", 64'(ack_ep2host), 64'(0));
    check("exhaust_no_pkt", 64'(dout_bft), 64'(0));
    step();
    vld_host2ep = 1'b0;
    inj(mk(1'b1, 7'd0, 32'd64));
    @(negedge clk);
    check("credit_return_64", 64'(credits), 64'(64));
    step();
    nok = 0;
    for (int i = 0; i < 64; i++) begin
      send_word(32'(i), '0, ok);
      if (!ok) nok++;
    end
    check("refill_64_accepted", 64'(nok), 64'(0));
    @(negedge clk);
    check("refill_credits", 64'(credits), 64'(0));
    step();
    inj(mk(1'b1, 7'd0, 32'd10));
    send_word(32'hEE, mk(1'b1, 7'd0, 32'd3), ok);
    check("net_accept", 64'(ok), 64'(1));
    @(negedge clk);
    check("net_credits", 64'(credits), 64'(12));
    step();
    for (int i = 0; i < 4; i++) begin
      inj(mk(1'b1, 7'd0, cv[i].pay));
      @(negedge clk);
      check("credit_sat", 64'(credits), 64'(cv[i].cred));
      step();
    end

    do_reset();
    for (int i = 0; i < 70; i++) inj(mk(1'b0, 7'(i), 32'h1000 + 32'(i)));
    @(negedge clk);
    check("rx_vld", 64'(vld_ep2host), 64'(1));
    check("rx_head", 64'(dout_host), 64'(32'h1000));
    step();
    ack_host2ep = 1'b1;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!vld_ep2host || dout_host !== 32'h1000 + 32'(i)) bad++;
      @(posedge clk);
    end
    #1;
    ack_host2ep = 1'b0;
    vld_host2ep = 1'b1;
    din_host = 32'h55;
    check("rx_pop_order", 64'(bad), 64'(0));
    ncred = 0;
    order_bad = 0;
    cnt = 0;
    cred_pkt = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dout_bft[48]) begin
        if (dout_bft[32]) begin
          ncred++;
          cred_pkt = dout_bft;
          if (cnt != 0) order_bad++;
        end else cnt++;
      end
    end
    vld_host2ep = 1'b0;
    check("cred_pkt_count", 64'(ncred), 64'(1));
    check("cred_pkt_value", 64'(cred_pkt), 64'({1'b1, 4'd7, 4'd1, 7'd0, 1'b1, 32'd64}));
    check("cred_before_data", 64'(order_bad), 64'(0));
    check("data_after_cred", 64'(cnt != 0), 64'(1));
    check("rx_remaining_head", 64'(dout_host), 64'(32'h1000 + 32'd64));
    step();

    do_reset();
    for (int i = 0; i < 256; i++) inj(mk(1'b0, 7'd0, 32'h2000 + 32'(i)));
    @(negedge clk);
    check("full_no_ovf", 64'(err_ovf), 64'(0));
    check("full_head", 64'(dout_host), 64'(32'h2000));
    step();
    ack_host2ep = 1'b1;
    inj(mk(1'b0, 7'd0, 32'h3000));
    ack_host2ep = 1'b0;
    @(negedge clk);
    check("push_pop_full_no_ovf", 64'(err_ovf), 64'(0));
    check("push_pop_full_head", 64'(dout_host), 64'(32'h2001));
    step();
    inj(mk(1'b0, 7'd0, 32'h3001));
    @(negedge clk);
    check("ovf_set", 64'(err_ovf), 64'(1));
    check("ovf_head_kept", 64'(dout_host), 64'(32'h2001));
    step();
    ack_host2ep = 1'b1;
    cnt = 0;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!vld_ep2host) break;
      exp_w = cnt < 255 ? 32'h2001 + 32'(cnt) : 32'h3000;
      if (dout_host !== exp_w) bad++;
      cnt++;
      @(posedge clk);
    end
    ack_host2ep = 1'b0;
    check("drain_count", 64'(cnt), 64'(256));
    check("drain_order", 64'(bad), 64'(0));
    check("ovf_sticky", 64'(err_ovf), 64'(1));
    step();

    for (int i = 0; i < 256; i++) inj(mk(1'b0, 7'd0, 32'h4000 + 32'(i)));
    send_word(32'h77, '0, ok);
    @(negedge clk);
    check("pre_reset_data_valid", 64'(dout_bft[48]), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_dout_bft", 64'(dout_bft), 64'(0));
    check("mid_reset_vld_ep2host", 64'(vld_ep2host), 64'(0));
    check("mid_reset_credits", 64'(credits), 64'(256));
    check("mid_reset_err_ovf", 64'(err_ovf), 64'(0));
    check("mid_reset_ack", 64'(ack_ep2host), 64'(0));
    step();
    reset = 1'b0;
    step();

`ifdef SEQ_CHECK_EN
    inj(mk(1'b0, 7'd0, 32'h1));
    inj(mk(1'b0, 7'd1, 32'h2));
    @(negedge clk);
    check("seq_in_order", 64'(err_seq), 64'(0));
    step();
    inj(mk(1'b0, 7'd3, 32'h3));
    @(negedge clk);
    check("seq_gap", 64'(err_seq), 64'(1));
    step();
    inj(mk(1'b0, 7'd4, 32'h4));
    @(negedge clk);
    check("seq_sticky", 64'(err_seq), 64'(1));
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
